// File: rtl/iomem_uart_pkg.sv
// iomem_uart_pkg: register map, STATUS bit positions, FSM state types and DIV clamp helper
package iomem_uart_pkg;
  localparam logic [3:0] REG_DIV = 4'h0;
  localparam logic [3:0] REG_DATA = 4'h4;
  localparam logic [3:0] REG_STATUS = 4'h8;
  localparam int ST_TX_FULL = 0;
  localparam int ST_TX_IDLE = 1;
  localparam int ST_RX_VALID = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_RX_FRAME_ERR = 4;
  localparam logic [15:0] DIV_MIN = 16'd4;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return v < DIV_MIN ? DIV_MIN : v;
  endfunction
endpackage

// File: rtl/iomem_uart_if.sv
// iomem_uart_if: iomem bus bundle
//   valid/addr/wdata/wstrb driven by the master (wstrb 0 = read)
//   ready/rdata driven by the slave (rdata 0 whenever ready is 0)
interface iomem_uart_if;
  logic valid;
  logic ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic [31:0] rdata;
  modport master(output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave(input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/iomem_uart_fifo.sv
// uart_fifo: synchronous FIFO
//   push/din in, pop/dout out (dout shows the head entry), full/empty flags,
//   count derived from the registered read/write pointers
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [WIDTH-1:0] din,
  input  logic pop,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign count = wr_ptr - rd_ptr;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = wr_ptr == rd_ptr;
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
endmodule

// File: rtl/iomem_uart.sv
// iomem_uart: memory-mapped UART on the iomem bus
//   clk, rst (async, active-high)
//   iomem : slave side of the iomem bus, 16-byte window at BASE_ADDR
//   uart_tx : serial out (idles high), uart_rx : serial in (asynchronous)
module iomem_uart
  import iomem_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int TX_DEPTH = 4,
  parameter int DIV_RESET = 104
) (
  input  logic clk,
  input  logic rst,
  iomem_uart_if.slave iomem,
  output logic uart_tx,
  input  logic uart_rx
);
  logic [3:0] off;
  logic sel, wr, stall, acc;
  logic [15:0] div, div_new;
  logic [31:0] status, rd_val;
  logic data_rd, clr_ovr, clr_ferr;
  logic fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;
  logic [$clog2(TX_DEPTH):0] fifo_count;
  logic tx_idle, tx_tick;
  tx_state_t tx_state;
  logic [15:0] tx_div, tx_cnt;
  logic [2:0] tx_bit;
  logic [7:0] tx_shift;
  rx_state_t rx_state;
  logic rx_s1, rx_s2, rx_last, rx_tick;
  logic [15:0] rx_div, rx_cnt;
  logic [2:0] rx_bit;
  logic [7:0] rx_shift, rx_byte;
  logic rx_valid, rx_overrun, rx_frame_err;
  logic unused_wdata;
  assign unused_wdata = ^iomem.wdata[31:16];
  assign off = iomem.addr[3:0];
  assign sel = iomem.valid && iomem.addr[31:4] == BASE_ADDR[31:4];
  assign wr = |iomem.wstrb;
  // a byte push into a full FIFO holds the bus until the transmitter frees a slot
  assign stall = off == REG_DATA && iomem.wstrb[0] && fifo_full;
  // the !ready term keeps a held valid from completing on consecutive cycles
  assign acc = sel && !iomem.ready && !stall;
  assign fifo_push = acc && off == REG_DATA && iomem.wstrb[0];
  assign data_rd = acc && !wr && off == REG_DATA;
  assign clr_ovr = acc && wr && off == REG_STATUS && iomem.wdata[ST_RX_OVERRUN];
  assign clr_ferr = acc && wr && off == REG_STATUS && iomem.wdata[ST_RX_FRAME_ERR];
  assign div_new = {iomem.wstrb[1] ? iomem.wdata[15:8] : div[15:8], iomem.wstrb[0] ? iomem.wdata[7:0] : div[7:0]};
  assign tx_idle = fifo_count == '0 && tx_state == TX_IDLE;
  always_comb begin
    status = '0;
    status[ST_TX_FULL] = fifo_full;
    status[ST_TX_IDLE] = tx_idle;
    status[ST_RX_VALID] = rx_valid;
    status[ST_RX_OVERRUN] = rx_overrun;
    status[ST_RX_FRAME_ERR] = rx_frame_err;
    rd_val = off == REG_DIV ? {16'b0, div} :
             off == REG_DATA ? (rx_valid ? {24'b0, rx_byte} : '1) :
             off == REG_STATUS ? status : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      iomem.ready <= 1'b0;
      iomem.rdata <= '0;
      div <= 16'(DIV_RESET);
    end else begin
      iomem.ready <= acc;
      iomem.rdata <= acc && !wr ? rd_val : '0;
      if (acc && wr && off == REG_DIV) div <= clamp_div(div_new);
    end
  uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(fifo_push),
    .din(iomem.wdata[7:0]),
    .pop(fifo_pop),
    .dout(fifo_dout),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );
  assign tx_tick = tx_cnt == tx_div - 1'b1;
  // a new frame starts from IDLE or directly at the end of a stop bit
  assign fifo_pop = !fifo_empty && (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_tick));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt <= '0;
      tx_div <= 16'(DIV_RESET);
      tx_bit <= '0;
      tx_shift <= '0;
      uart_tx <= 1'b1;
    end else if (fifo_pop) begin
      tx_state <= TX_START;
      tx_cnt <= '0;
      tx_div <= div;
      tx_shift <= fifo_dout;
      uart_tx <= 1'b0;
    end else if (tx_state != TX_IDLE) begin
      tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
      if (tx_tick)
        case (tx_state)
          TX_START: begin
            tx_state <= TX_DATA;
            tx_bit <= '0;
            uart_tx <= tx_shift[0];
          end
          TX_DATA: begin
            tx_state <= tx_bit == 3'd7 ? TX_STOP : TX_DATA;
            tx_bit <= tx_bit + 1'b1;
            tx_shift <= tx_shift >> 1;
            uart_tx <= tx_bit == 3'd7 ? 1'b1 : tx_shift[1];
          end
          default: tx_state <= TX_IDLE;
        endcase
    end
  // START samples mid-bit at DIV/2; later bits are one DIV apart from there
  assign rx_tick = rx_state == RX_START ? rx_cnt == (rx_div >> 1) - 1'b1 : rx_cnt == rx_div - 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_last <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt <= '0;
      rx_div <= 16'(DIV_RESET);
      rx_bit <= '0;
      rx_shift <= '0;
      rx_byte <= '0;
      rx_valid <= 1'b0;
      rx_overrun <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_last <= rx_s2;
      if (data_rd) rx_valid <= 1'b0;
      if (clr_ovr) rx_overrun <= 1'b0;
      if (clr_ferr) rx_frame_err <= 1'b0;
      rx_cnt <= rx_tick ? '0 : rx_cnt + 1'b1;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_div <= div;
          rx_bit <= '0;
          if (rx_last && !rx_s2) rx_state <= RX_START;
        end
        RX_START:
          if (rx_tick) rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
        RX_DATA:
          if (rx_tick) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end
        default:
          if (rx_tick) begin
            rx_state <= RX_IDLE;
            // flag sets come after the bus clears so a same-cycle set wins
            if (!rx_s2) rx_frame_err <= 1'b1;
            else if (rx_valid && !data_rd) rx_overrun <= 1'b1;
            else begin
              rx_byte <= rx_shift;
              rx_valid <= 1'b1;
            end
          end
      endcase
    end
endmodule
